// File: rtl/aha_tlx_train_pkg.sv
// aha_tlx_train_pkg: shared FSM state encoding and PRBS7 constants for the TLX training output stage
package aha_tlx_train_pkg;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAINING = 2'd1,
        ST_FINISH   = 2'd2
    } train_state_e;
    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;
endpackage

// File: rtl/aha_tlx_prbs7.sv
// aha_tlx_prbs7: Fibonacci PRBS7 (x^7+x^6+1) source, output bit 6; only built with AHA_TLX_TRAIN_PRBS_EN
module aha_tlx_prbs7
    import aha_tlx_train_pkg::*;
(
    input  logic CLK,
    input  logic RESETn,
    input  logic LOAD,
    input  logic ADVANCE,
    output logic BIT
);
    logic [6:0] lfsr;
    // reseed on load, otherwise shift one step per advance
    always_ff @(posedge CLK) begin
        if (!RESETn)
            lfsr <= PRBS7_SEED;
        else if (LOAD)
            lfsr <= PRBS7_SEED;
        else if (ADVANCE)
            lfsr <= {lfsr[5:0], lfsr[PRBS7_TAP_HI] ^ lfsr[PRBS7_TAP_LO]};
    end
    assign BIT = lfsr[6];
endmodule

// File: rtl/aha_tlx_multi_lane_output_capsule.sv
// aha_tlx_multi_lane_output_capsule: per-lane TLX passthrough or repeating training pattern; PRBS7 source under AHA_TLX_TRAIN_PRBS_EN
module aha_tlx_multi_lane_output_capsule
    import aha_tlx_train_pkg::*;
#(
    parameter int LANES = 4,
    parameter int SEQ_W = 32,
    parameter int CNT_W = 32
)
(
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [LANES-1:0] D_IN,
    input  logic             START,
    input  logic             CLEAR,
    input  logic [SEQ_W-1:0] SEQUENCE,
    input  logic [CNT_W-1:0] LENGTH,
    input  logic             AUTO_STOP,
    input  logic [LANES-1:0] MODE,
    input  logic [LANES-1:0] LANE_INV,
`ifdef AHA_TLX_TRAIN_PRBS_EN
    input  logic             PATTERN_SEL,
`endif
    output logic             DONE,
    output logic             ACTIVE,
    output logic [CNT_W-1:0] SEQ_COUNT,
    output logic [LANES-1:0] D_OUT
);
    localparam int IDX_W = $clog2(SEQ_W);

    train_state_e     state, state_d;
    logic [IDX_W-1:0] idx;
    logic [LANES-1:0] tr;
    logic             start_q, clear_q, start_p, clear_p;
    logic             accept, training, at_len, done_w, tick, run_on, pat_bit;

    assign start_p  = START & ~start_q;
    assign clear_p  = CLEAR & ~clear_q;
    assign training = (state == ST_TRAINING);
    assign accept   = (state == ST_IDLE) & start_p & ~clear_p;
    assign at_len   = AUTO_STOP & (SEQ_COUNT == LENGTH);
    assign done_w   = training & at_len;
    assign run_on   = training & ~done_w & ~clear_p;
    assign tick     = training & (idx == IDX_W'(SEQ_W - 1));
    assign ACTIVE   = training & ~at_len;
    assign D_OUT    = (MODE & tr) | (~MODE & D_IN);

`ifdef AHA_TLX_TRAIN_PRBS_EN
    logic prbs_bit;
    aha_tlx_prbs7 u_prbs (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .LOAD    (accept),
        .ADVANCE (training),
        .BIT     (prbs_bit)
    );
    assign pat_bit = PATTERN_SEL ? prbs_bit : SEQUENCE[idx];
`else
    assign pat_bit = SEQUENCE[idx];
`endif

    // next state: clear beats start in idle, clear beats completion in training
    always_comb begin
        state_d = (state == ST_IDLE)     ? (accept ? ST_TRAINING : ST_IDLE) :
                  (state == ST_TRAINING) ? (clear_p ? ST_IDLE : done_w ? ST_FINISH : ST_TRAINING) :
                                           ST_IDLE;
    end

    // previous START/CLEAR levels; zero in reset so a level held high out of reset still edges
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            start_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            start_q <= START;
            clear_q <= CLEAR;
        end
    end

    // FSM, bit index, repetition count, sticky done and registered training bits
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            SEQ_COUNT <= '0;
            DONE      <= 1'b0;
            tr        <= '0;
        end else begin
            state     <= state_d;
            idx       <= run_on ? idx + IDX_W'(1) : '0;
            SEQ_COUNT <= (clear_p | accept) ? '0 : tick ? SEQ_COUNT + CNT_W'(1) : SEQ_COUNT;
            DONE      <= (clear_p | accept) ? 1'b0 : done_w ? 1'b1 : DONE;
            tr        <= run_on ? ({LANES{pat_bit}} ^ LANE_INV) : '0;
        end
    end
endmodule

// File: tb/tb_aha_tlx_multi_lane_output_capsule.sv
// tb_aha_tlx_multi_lane_output_capsule: randomized runs checked against a cycle-offset model of the training timeline
module tb_aha_tlx_multi_lane_output_capsule;
    localparam int LANES = 4;
    localparam int W     = 32;
    localparam int CNT_W = 32;
    localparam int INF   = 1 << 30;

    logic             CLK = 1'b0;
    logic             RESETn;
    logic [LANES-1:0] D_IN;
    logic             START, CLEAR, AUTO_STOP;
    logic [W-1:0]     SEQUENCE;
    logic [CNT_W-1:0] LENGTH;
    logic [LANES-1:0] MODE, LANE_INV;
    logic             DONE, ACTIVE;
    logic [CNT_W-1:0] SEQ_COUNT;
    logic [LANES-1:0] D_OUT;
`ifdef AHA_TLX_TRAIN_PRBS_EN
    logic             PATTERN_SEL = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    aha_tlx_multi_lane_output_capsule #(.LANES(LANES), .SEQ_W(W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .D_IN      (D_IN),
        .START     (START),
        .CLEAR     (CLEAR),
        .SEQUENCE  (SEQUENCE),
        .LENGTH    (LENGTH),
        .AUTO_STOP (AUTO_STOP),
        .MODE      (MODE),
        .LANE_INV  (LANE_INV),
`ifdef AHA_TLX_TRAIN_PRBS_EN
        .PATTERN_SEL (PATTERN_SEL),
`endif
        .DONE      (DONE),
        .ACTIVE    (ACTIVE),
        .SEQ_COUNT (SEQ_COUNT),
        .D_OUT     (D_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One training run, cycle c counted from the START rising edge. n = LENGTH,
    // k = cycle of a CLEAR rising edge (-1 none), s2 = cycle of a second START edge (0 none).
    task automatic run(input logic [W-1:0] seq, input int n, input bit auto_stop,
                       input logic [LANES-1:0] mode, input logic [LANES-1:0] inv,
                       input int k, input int s2);
        int tr_end, act_end, last, cnt;
        logic [LANES-1:0] exp_tr;
        bit on, exp_done;
        tr_end  = auto_stop ? n * W + 1 : INF;
        act_end = auto_stop ? n * W : INF;
        if (k >= 0 && k < tr_end)  tr_end  = k;
        if (k >= 0 && k < act_end) act_end = k;
        last = ((k > tr_end) ? k : tr_end) + 3;
        SEQUENCE  = seq;
        LENGTH    = CNT_W'(n);
        AUTO_STOP = auto_stop;
        MODE      = mode;
        LANE_INV  = inv;
        for (int c = 0; c <= last; c++) begin
            @(negedge CLK);
            START = (c <= 2) || (s2 > 0 && (c == s2 || c == s2 + 1));
            CLEAR = (c == k);
            D_IN  = LANES'($urandom);
            #1;
            on     = (c >= 2) && (c <= tr_end);
            exp_tr = on ? ({LANES{seq[(c - 2) % W]}} ^ inv) : '0;
            chk("dout", D_OUT, (mode & exp_tr) | (~mode & D_IN));
            chk("active", ACTIVE, (c >= 1) && (c <= act_end));
            if (c >= 1) begin
                cnt = (c - 1) / W;
                if (auto_stop && cnt > n) cnt = n;
                if (k >= 0 && c >= k + 1) cnt = 0;
                exp_done = auto_stop && (c >= n * W + 2) && !(k >= 0 && c >= k + 1);
                chk("done", DONE, exp_done);
                chk("count", SEQ_COUNT, cnt);
            end
        end
        START = 1'b0;
        CLEAR = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, k, s2, e;
        RESETn = 1'b0; START = 1'b0; CLEAR = 1'b0; AUTO_STOP = 1'b1;
        SEQUENCE = '0; LENGTH = '0; MODE = 4'hA; LANE_INV = 4'hF; D_IN = 4'h5;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        D_IN = 4'h6;
        #1;
        chk("rst_done", DONE, 0);
        chk("rst_active", ACTIVE, 0);
        chk("rst_count", SEQ_COUNT, 0);
        chk("rst_dout", D_OUT, 4'h4);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);

        run(32'hA5A5_0F0F, 3, 1'b1, 4'hF, 4'b0101, -1, 0);
        run(W'($urandom), 0, 1'b1, 4'hF, LANES'($urandom), -1, 0);
        run(W'($urandom), 0, 1'b0, 4'hF, LANES'($urandom), 200, 50);
        run(W'($urandom), 2, 1'b1, 4'b0010, LANES'($urandom), -1, 0);
        run(W'($urandom), 2, 1'b1, 4'hF, LANES'($urandom), 0, 0);
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 2);
            k = -1;
            s2 = 0;
            if ($urandom_range(0, 2) == 0) k = $urandom_range(0, n * W + 4);
            e = (k >= 0 && k < n * W + 1) ? k : n * W + 1;
            if (e >= 10 && $urandom_range(0, 1) == 1) s2 = $urandom_range(4, e - 2);
            run(W'($urandom), n, 1'b1, LANES'($urandom), LANES'($urandom), k, s2);
        end

        SEQUENCE = W'($urandom); AUTO_STOP = 1'b0; MODE = 4'b0110; LANE_INV = 4'b0011;
        @(negedge CLK);
        START = 1'b1;
        repeat (40) @(negedge CLK);
        START = 1'b0;
        RESETn = 1'b0;
        D_IN = 4'h9;
        @(posedge CLK);
        #1;
        chk("midrst_done", DONE, 0);
        chk("midrst_active", ACTIVE, 0);
        chk("midrst_count", SEQ_COUNT, 0);
        chk("midrst_dout", D_OUT, 4'h9 & ~4'b0110);
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (3) @(negedge CLK);
        run(W'($urandom), 1, 1'b1, LANES'($urandom), LANES'($urandom), -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
